// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit geometry, scan defaults, hex segment table.
// Segment bits are ordered {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam int unsigned SCAN_DIV_DEF     = 10000;
    localparam int unsigned BLANK_CYCLES_DEF = 500;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0;

    // Entry n holds the glyph for hex digit n.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

    typedef struct packed {
        logic [SEG_W-1:0]      segments;
        logic                  dp;
        logic [NUM_DIGITS-1:0] digit_en_n;
        logic                  frame_tick;
    } pins_t;

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-side bus of the scan mux: value/load/enable in, multiplexed pins out.
interface seg7_scan_mux_if;
    import seg7_pkg::*;

    logic                  ena;
    logic [VAL_W-1:0]      value_in;
    logic [NUM_DIGITS-1:0] dp_in;
    logic                  load;
    logic [SEG_W-1:0]      segments;
    logic                  dp;
    logic [NUM_DIGITS-1:0] digit_en_n;
    logic                  frame_tick;

    modport master (
        output ena, value_in, dp_in, load,
        input  segments, dp, digit_en_n, frame_tick
    );

    modport slave (
        input  ena, value_in, dp_in, load,
        output segments, dp, digit_en_n, frame_tick
    );

endinterface

// File: rtl/seg7_scan_mux_dec.sv
// Combinational hex nibble to 7-segment glyph decoder.
module seg7_scan_mux_dec
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit 7-segment driver with blanking dead-time and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input logic            clk,
    input logic            rst_n,
    seg7_scan_mux_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [VAL_W-1:0]      pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_vld;
    logic                  wrap_q;
    pins_t                 pins_q;

    pins_t                 pins_nxt;
    phase_e                phase;
    logic                  slot_end;
    logic                  frame_end;
    logic                  digit_lit;
    logic [NIB_W-1:0]      nibble;
    logic [SEG_W-1:0]      seg_c;

    seg7_scan_mux_dec u_dec (
        .nibble (nibble),
        .seg_c  (seg_c)
    );

    // Scan position, frame boundary and current digit selection.
    always_comb begin
        slot_end  = (slot_cnt == SLOT_LAST);
        frame_end = bus.ena && slot_end && (idx == IDX_LAST);
        phase     = (slot_cnt < BLANK_END) ? PH_BLANK : PH_ON;
        nibble    = disp_val[{idx, 2'b00} +: NIB_W];
`ifdef SEG7_SCAN_LZB_EN
        // A digit stays dark when it and everything above it is zero, unless its dp is on.
        digit_lit = (idx == '0) || disp_dp[idx] || ((disp_val >> {idx, 2'b00}) != '0);
`else
        digit_lit = 1'b1;
`endif
    end

    // Slot counter and digit index advance only while scanning is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
            wrap_q   <= 1'b0;
        end else if (bus.ena) begin
            wrap_q <= frame_end;
            if (slot_end) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + CNT_W'(1);
            end
        end
    end

    // Loads park in the pending buffer and reach the display only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (frame_end && bus.load) begin
                disp_val <= bus.value_in;
                disp_dp  <= bus.dp_in;
                pend_vld <= 1'b0;
            end else if (frame_end && pend_vld) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                pend_vld <= 1'b0;
            end else if (bus.load) begin
                pend_val <= bus.value_in;
                pend_dp  <= bus.dp_in;
                pend_vld <= 1'b1;
            end
        end
    end

    // Next pin values: blank unless scanning, in the ON phase and the digit is lit.
    always_comb begin
        pins_nxt            = '0;
        pins_nxt.segments   = SEG_OFF;
        pins_nxt.digit_en_n = '1;
        if (bus.ena) begin
            pins_nxt.frame_tick = wrap_q;
            if (phase == PH_ON && digit_lit) begin
                pins_nxt.digit_en_n[idx] = 1'b0;
                pins_nxt.segments        = seg_c;
                pins_nxt.dp              = disp_dp[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins_q            <= '0;
            pins_q.digit_en_n <= '1;
        end else begin
            pins_q <= pins_nxt;
        end
    end

    assign bus.segments   = pins_q.segments;
    assign bus.dp         = pins_q.dp;
    assign bus.digit_en_n = pins_q.digit_en_n;
    assign bus.frame_tick = pins_q.frame_tick;

endmodule
